sobel_stream: RTL and testbench
===============================

// Module: sobel_stream
// PURPOSE
//  Streaming Sobel edge detector: accepts raster pixels one at a time over a valid/ready
//  handshake and builds the 3x3 window internally with two line buffers.
//  Emits |Gx|+|Gy| per pixel, optionally thresholded to a binary edge map.
//  Parametrised successor of the fixed 8-bit, externally-windowed top_level core.
//  Sits between the frame source and the frame writer.
// PARAMETERS
//  PIX_W     8   pixel width in bits (4..12)
//  IMG_W     64  pixels per line (>=3)
//  IMG_H     64  lines per frame (>=3)
//  THRESH_EN 0   1: out = (mag>=threshold) ? all-ones : 0; 0: out = mag
// PORTS
//  clk        in   1      clock, rising edge
//  rst        in   1      reset, synchronous, active-high
//  in_valid   in   1      in_pix/in_sof valid
//  in_ready   out  1      block accepts input this cycle
//  in_pix     in   PIX_W  raster pixel, unsigned
//  in_sof     in   1      first pixel of frame (row 0, col 0)
//  threshold  in   PIX_W  edge threshold, sampled per output, used when THRESH_EN=1
//  out_valid  out  1      out_* valid
//  out_ready  in   1      downstream accepts output
//  out_pix    out  PIX_W  edge magnitude of centre pixel
//  out_sof    out  1      output is pixel (0,0)
//  out_eol    out  1      output is last pixel of a line
// BEHAVIOUR
//  - Reset: state=IDLE, counters 0, in_ready=0, out_valid=0, out_pix=0, out_sof=0, out_eol=0.
//    Line-buffer contents are not reset.
//  - FSM IDLE -> FILL -> RUN -> FLUSH -> IDLE.
//    IDLE:  in_ready=1; non-sof pixels are accepted and dropped; an accepted sof pixel
//           goes to FILL and counts as input 0.
//    FILL:  in_ready=1; no output; after IMG_W+1 accepted pixels -> RUN.
//    RUN:   in_ready = !out_valid | out_ready. Each accepted input k loads the output
//           register with the result for centre index k-(IMG_W+1) the next cycle.
//           On accepting input IMG_W*IMG_H-1 -> FLUSH.
//    FLUSH: in_ready=0; emits the remaining IMG_W+1 outputs (all border, value 0)
//           under out_ready, then -> IDLE.
//  - Handshake: transfer when valid&ready. out_* held stable while out_valid & !out_ready.
//    The output count per frame is exactly IMG_W*IMG_H.
//  - Border: centre on row 0, row IMG_H-1, col 0 or col IMG_W-1 -> out_pix=0 in all modes.
//  - Arithmetic: window p0..p8, row-major, p4 = centre.
//    Gx = (p2+2p5+p8)-(p0+2p3+p6); Gy = (p6+2p7+p8)-(p0+2p1+p2).
//    Signed, PIX_W+3 bits, no overflow. mag = |Gx|+|Gy|, saturated to 2^PIX_W-1.
//  - out_sof=1 for centre (0,0); out_eol=1 for col IMG_W-1.
//  - in_sof accepted in FILL/RUN: the current frame is abandoned and the pending output
//    register is dropped (out_valid=0 next cycle). Restart FILL with this pixel as input 0.
//  - Column counter wraps at IMG_W-1 to 0 and increments the row; the row wraps at IMG_H-1.
//  - rst mid-frame: immediate return to the reset state; the partial frame is discarded.
// STRUCTURE
//  - sobel_pkg: state enum, kernel coefficients, function sat_mag(gx,gy,PIX_W).
//  - Sub-module sobel_line_buffer #(PIX_W,IMG_W): two IMG_W-deep rows, single col pointer.
//    Per write it returns the 3 column taps (row-2, row-1, current).
//  - Top level: FSM, col/row counters, 3x3 shift window, Sobel datapath, output register.
// TESTING (IMG_W=IMG_H=8, PIX_W=8 unless noted)
//  1 Flat frame, all pixels 0x40 -> 64 outputs, all 0x00; sof on output 0, eol on every 8th.
//  2 Vertical step: cols 0-3 = 0x00, cols 4-7 = 0xFF -> interior cols 3,4 = 0xFF
//    (saturated from 1020); cols 1,2,5,6 = 0x00; border = 0x00.
//  3 Ramp pix = 10*col, THRESH_EN=0 -> interior = 0x50.
//    THRESH_EN=1: threshold 0x50 -> interior 0xFF; threshold 0x51 -> interior 0x00.
//  4 Test 2 with out_ready pseudo-random (50%) and in_valid gaps -> output sequence
//    identical to test 2; no drops or duplicates; out_* stable while stalled.
//  5 in_sof re-asserted at input 20 of a frame, then a full flat frame -> no stale
//    outputs after the restart; exactly 64 outputs for the new frame.
//  6 rst asserted in RUN for 1 cycle -> next cycle out_valid=0, in_ready=0;
//    the following full frame matches test 2.

Source files
------------

// File: rtl/sobel_pkg.sv
// sobel_pkg: shared definitions for the streaming Sobel edge detector.
//   sobel_state_e : frame FSM states (IDLE -> FILL -> RUN -> FLUSH -> IDLE)
//   KX / KY       : 3x3 kernel coefficients, row-major, index 4 = centre
//   ACC_W         : working width of the gradient datapath (covers PIX_W up to 12)
//   sat_mag       : |gx|+|gy| clamped to 2^pix_w-1
package sobel_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FILL  = 2'd1,
      ST_RUN   = 2'd2,
      ST_FLUSH = 2'd3
   } sobel_state_e;

   localparam int ACC_W = 16;

   localparam int KX [9] = '{-1, 0, 1, -2, 0, 2, -1, 0, 1};
   localparam int KY [9] = '{-1, -2, -1, 0, 0, 0, 1, 2, 1};

   function automatic logic [ACC_W-1:0] sat_mag(input logic signed [ACC_W-1:0] gx,
                                                 input logic signed [ACC_W-1:0] gy,
                                                 input int                      pix_w);
      logic [ACC_W-1:0] ax;
      logic [ACC_W-1:0] ay;
      logic [ACC_W-1:0] sum;
      logic [ACC_W-1:0] maxv;
      ax   = gx[ACC_W-1] ? -gx : gx;
      ay   = gy[ACC_W-1] ? -gy : gy;
      sum  = ax + ay;
      maxv = (ACC_W'(1) << pix_w) - ACC_W'(1);
      return (sum > maxv) ? maxv : sum;
   endfunction

endpackage

// File: rtl/sobel_line_buffer.sv
// sobel_line_buffer: two IMG_W-deep line memories addressed by one column pointer.
// On each write the pixel stored two lines up, the pixel one line up and the
// incoming pixel at that column are presented as the three vertical taps; the
// write then ages row-1 into row-2 and stores the new pixel as row-1.
// Contents are never reset: every tap that matters is rewritten before use.
// Ports:
//   clk        clock, rising edge
//   we_i       write strobe (one accepted pixel)
//   col_i      column of the incoming pixel
//   pix_i      incoming pixel
//   tap_top_o  pixel at col_i, two lines above
//   tap_mid_o  pixel at col_i, one line above
//   tap_cur_o  incoming pixel
module sobel_line_buffer #(
   parameter  int PIX_W = 8,
   parameter  int IMG_W = 64,
   localparam int CW    = $clog2(IMG_W)
) (
   input  logic             clk,
   input  logic             we_i,
   input  logic [CW-1:0]    col_i,
   input  logic [PIX_W-1:0] pix_i,
   output logic [PIX_W-1:0] tap_top_o,
   output logic [PIX_W-1:0] tap_mid_o,
   output logic [PIX_W-1:0] tap_cur_o
);

   logic [PIX_W-1:0] row1_q [IMG_W];
   logic [PIX_W-1:0] row2_q [IMG_W];

   assign tap_top_o = row2_q[col_i];
   assign tap_mid_o = row1_q[col_i];
   assign tap_cur_o = pix_i;

   always_ff @(posedge clk) begin
      if (we_i) begin
         row2_q[col_i] <= row1_q[col_i];
         row1_q[col_i] <= pix_i;
      end
   end

endmodule

// File: rtl/sobel_stream.sv
// sobel_stream: streaming 3x3 Sobel edge detector over a raster pixel stream.
// Each accepted input shifts a new column into the 3x3 window; the window centre
// trails the input by IMG_W+1 pixels, so the first IMG_W+1 inputs only fill and
// the last IMG_W+1 outputs (all border) are flushed after input ends.
// Handshake: a beat transfers on a rising edge where valid && ready; out_* stay
// stable while out_valid && !out_ready; in_ready never depends on in_valid.
// Ports:
//   clk, rst     clock / synchronous active-high reset
//   in_valid     in_pix/in_sof valid          in_ready   block accepts input
//   in_pix       raster pixel                 in_sof     pixel (0,0) of a frame
//   threshold    edge threshold (THRESH_EN=1)
//   out_valid    out_* valid                  out_ready  downstream accepts
//   out_pix      edge magnitude / edge flag   out_sof    output is pixel (0,0)
//   out_eol      output is last pixel of a line
//   dbg_state_o  current FSM state
module sobel_stream
   import sobel_pkg::*;
#(
   parameter int PIX_W     = 8,
   parameter int IMG_W     = 64,
   parameter int IMG_H     = 64,
   parameter int THRESH_EN = 0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [PIX_W-1:0] in_pix,
   input  logic             in_sof,
   input  logic [PIX_W-1:0] threshold,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [PIX_W-1:0] out_pix,
   output logic             out_sof,
   output logic             out_eol,
   output sobel_state_e     dbg_state_o
);

   localparam int CW = $clog2(IMG_W);
   localparam int RW = $clog2(IMG_H);
   localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
   localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

   sobel_state_e     state_q;
   logic             started_q;
   logic [CW-1:0]    col_q, col_d, ocol_q, ocol_d;
   logic [RW-1:0]    row_q, row_d, orow_q, orow_d;
   logic             out_valid_q, out_sof_q, out_eol_q, out_last_q;
   logic [PIX_W-1:0] out_pix_q;
   logic [PIX_W-1:0] win_q [9];
   logic [PIX_W-1:0] win_d [9];
   logic [PIX_W-1:0] tap_top, tap_mid, tap_cur;
   logic             ready_st, acc, lb_we, border, last_in;
   logic [CW-1:0]    wr_col;
   logic signed [ACC_W-1:0] gx, gy;
   logic [ACC_W-1:0] mag;
   logic [PIX_W-1:0] res;

   // in_ready is held low for the first cycle after reset.
   always_comb begin
      ready_st = 1'b0;
      case (state_q)
         ST_IDLE, ST_FILL: ready_st = 1'b1;
         ST_RUN:           ready_st = !out_valid_q || out_ready;
         default:          ready_st = 1'b0;
      endcase
   end

   assign in_ready    = started_q && ready_st;
   assign acc         = in_valid && in_ready;
   // Non-sof pixels seen in IDLE are dropped and must not touch the line buffer.
   assign lb_we       = acc && (in_sof || (state_q != ST_IDLE));
   assign wr_col      = in_sof ? '0 : col_q;
   assign last_in     = (col_q == COL_LAST) && (row_q == ROW_LAST);
   assign out_valid   = out_valid_q;
   assign out_pix     = out_pix_q;
   assign out_sof     = out_sof_q;
   assign out_eol     = out_eol_q;
   assign dbg_state_o = state_q;

   sobel_line_buffer #(.PIX_W(PIX_W), .IMG_W(IMG_W)) u_lb (
      .clk       (clk),
      .we_i      (lb_we),
      .col_i     (wr_col),
      .pix_i     (in_pix),
      .tap_top_o (tap_top),
      .tap_mid_o (tap_mid),
      .tap_cur_o (tap_cur)
   );

   // Raster counters for the next input and the next output centre.
   always_comb begin
      col_d  = (col_q == COL_LAST) ? '0 : col_q + CW'(1);
      row_d  = (col_q != COL_LAST) ? row_q : ((row_q == ROW_LAST) ? '0 : row_q + RW'(1));
      ocol_d = (ocol_q == COL_LAST) ? '0 : ocol_q + CW'(1);
      orow_d = (ocol_q != COL_LAST) ? orow_q : ((orow_q == ROW_LAST) ? '0 : orow_q + RW'(1));
   end

   // Window after this cycle's shift; the result is computed on it so the
   // output register loads on the same edge that accepts the input.
   always_comb begin
      win_d[0] = win_q[1]; win_d[1] = win_q[2]; win_d[2] = tap_top;
      win_d[3] = win_q[4]; win_d[4] = win_q[5]; win_d[5] = tap_mid;
      win_d[6] = win_q[7]; win_d[7] = win_q[8]; win_d[8] = tap_cur;
   end

   always_ff @(posedge clk) begin
      if (lb_we) begin
         win_q <= win_d;
      end
   end

   always_comb begin
      gx = '0;
      gy = '0;
      for (int i = 0; i < 9; i++) begin
         gx = gx + ACC_W'(KX[i]) * $signed(ACC_W'(win_d[i]));
         gy = gy + ACC_W'(KY[i]) * $signed(ACC_W'(win_d[i]));
      end
      mag    = sat_mag(gx, gy, PIX_W);
      border = (ocol_q == '0) || (ocol_q == COL_LAST) || (orow_q == '0) || (orow_q == ROW_LAST);
      res    = '0;
      if (border) begin
         res = '0;
      end else if (THRESH_EN != 0) begin
         res = (mag >= ACC_W'(threshold)) ? '1 : '0;
      end else begin
         res = mag[PIX_W-1:0];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         started_q   <= 1'b0;
         col_q       <= '0;
         row_q       <= '0;
         ocol_q      <= '0;
         orow_q      <= '0;
         out_valid_q <= 1'b0;
         out_pix_q   <= '0;
         out_sof_q   <= 1'b0;
         out_eol_q   <= 1'b0;
         out_last_q  <= 1'b0;
      end else begin
         started_q <= 1'b1;
         if (out_valid_q && out_ready) begin
            out_valid_q <= 1'b0;
         end
         // A sof accepted in any input-taking state restarts the frame with it as input 0.
         if (acc && in_sof) begin
            state_q     <= ST_FILL;
            col_q       <= CW'(1);
            row_q       <= '0;
            ocol_q      <= '0;
            orow_q      <= '0;
            out_last_q  <= 1'b0;
            out_valid_q <= 1'b0;
         end else begin
            case (state_q)
               ST_FILL: begin
                  if (acc) begin
                     col_q <= col_d;
                     row_q <= row_d;
                     if ((row_q == RW'(1)) && (col_q == '0)) begin
                        state_q <= ST_RUN;
                     end
                  end
               end
               ST_RUN: begin
                  if (acc) begin
                     col_q       <= col_d;
                     row_q       <= row_d;
                     out_valid_q <= 1'b1;
                     out_pix_q   <= res;
                     out_sof_q   <= (ocol_q == '0) && (orow_q == '0);
                     out_eol_q   <= (ocol_q == COL_LAST);
                     out_last_q  <= (ocol_q == COL_LAST) && (orow_q == ROW_LAST);
                     ocol_q      <= ocol_d;
                     orow_q      <= orow_d;
                     if (last_in) begin
                        state_q <= ST_FLUSH;
                     end
                  end
               end
               ST_FLUSH: begin
                  if (!out_valid_q || out_ready) begin
                     if (out_last_q) begin
                        state_q    <= ST_IDLE;
                        out_last_q <= 1'b0;
                     end else begin
                        out_valid_q <= 1'b1;
                        out_pix_q   <= res;
                        out_sof_q   <= (ocol_q == '0) && (orow_q == '0);
                        out_eol_q   <= (ocol_q == COL_LAST);
                        out_last_q  <= (ocol_q == COL_LAST) && (orow_q == ROW_LAST);
                        ocol_q      <= ocol_d;
                        orow_q      <= orow_d;
                     end
                  end
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_sobel_stream.sv
// Bench for sobel_stream on an 8x8 frame: one instance in magnitude mode and one
// in threshold mode share the same input stream. Expected words are pushed when
// a frame is driven and popped by the output monitor on each output transfer.
module tb_sobel_stream;
  import sobel_pkg::*;

  localparam int W  = 8;
  localparam int H  = 8;
  localparam int EW = 19;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic [7:0] in_pix = 8'h00;
  logic       in_sof = 1'b0;
  logic [7:0] threshold = 8'h80;
  logic       out_ready = 1'b1;
  logic       rnd_ready = 1'b0;
  logic       mon_en = 1'b1;

  logic       in_ready_m, out_valid_m, out_sof_m, out_eol_m;
  logic       in_ready_t, out_valid_t, out_sof_t, out_eol_t;
  logic [7:0] out_pix_m, out_pix_t;
  sobel_state_e dbg_state_m, dbg_state_t;

  int tests_run = 0;
  int tests_failed = 0;
  int n_out = 0;

  logic [7:0]    img [H][W];
  logic [EW-1:0] exp_q [$];

  sobel_stream #(.PIX_W(8), .IMG_W(W), .IMG_H(H), .THRESH_EN(0)) dut_m (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_m), .in_pix(in_pix),
    .in_sof(in_sof), .threshold(threshold), .out_valid(out_valid_m), .out_ready(out_ready),
    .out_pix(out_pix_m), .out_sof(out_sof_m), .out_eol(out_eol_m), .dbg_state_o(dbg_state_m));

  sobel_stream #(.PIX_W(8), .IMG_W(W), .IMG_H(H), .THRESH_EN(1)) dut_t (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_t), .in_pix(in_pix),
    .in_sof(in_sof), .threshold(threshold), .out_valid(out_valid_t), .out_ready(out_ready),
    .out_pix(out_pix_t), .out_sof(out_sof_t), .out_eol(out_eol_t), .dbg_state_o(dbg_state_t));

  // clock / reset block
  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    out_ready = rnd_ready ? ($urandom_range(0, 1) == 1) : 1'b1;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // image patterns: 0 flat 0x40, 1 vertical step at col 4, 2 ramp 10*col
  task automatic set_img(input int mode);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        case (mode)
          0:       img[r][c] = 8'h40;
          1:       img[r][c] = (c >= 4) ? 8'hFF : 8'h00;
          default: img[r][c] = 8'(10 * c);
        endcase
  endtask

  // reference: {valid, sof, eol, magnitude-mode pixel, threshold-mode pixel}
  function automatic logic [EW-1:0] exp_word(input int r, input int c);
    int a [3][3];
    int gx, gy, mag;
    logic [7:0] m, t;
    m = 8'h00;
    t = 8'h00;
    if (r != 0 && r != H-1 && c != 0 && c != W-1) begin
      for (int i = 0; i < 3; i++)
        for (int j = 0; j < 3; j++)
          a[i][j] = int'(img[r-1+i][c-1+j]);
      gx = (a[0][2] + 2*a[1][2] + a[2][2]) - (a[0][0] + 2*a[1][0] + a[2][0]);
      gy = (a[2][0] + 2*a[2][1] + a[2][2]) - (a[0][0] + 2*a[0][1] + a[0][2]);
      mag = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
      if (mag > 255) mag = 255;
      m = 8'(mag);
      t = (mag >= int'(threshold)) ? 8'hFF : 8'h00;
    end
    return {1'b1, (r == 0 && c == 0), (c == W-1), m, t};
  endfunction

  // output monitor / scoreboard, sampled on the falling edge
  task automatic monitor();
    logic          stall_prev = 1'b0;
    logic [EW-1:0] held = '0;
    logic [EW-1:0] got, e;
    forever begin
      @(negedge clk);
      got = {out_valid_t, out_sof_m, out_eol_m, out_pix_m, out_pix_t};
      if (!mon_en) begin
        stall_prev = 1'b0;
      end else begin
        if (stall_prev) begin
          tests_run++;
          if ({out_valid_m, got[EW-2:0]} !== held) begin
            tests_failed++;
            $display("FAIL stall_stable: got %h required %h", {out_valid_m, got[EW-2:0]}, held);
          end
        end
        if (out_valid_m && out_ready) begin
          n_out++;
          tests_run++;
          if (exp_q.size() == 0) begin
            tests_failed++;
            $display("FAIL unexpected_output: got %h with empty expected queue", got);
          end else begin
            e = exp_q.pop_front();
            if (got !== e) begin
              tests_failed++;
              $display("FAIL out_word #%0d: got %h required %h", n_out, got, e);
            end
          end
        end
        stall_prev = out_valid_m && !out_ready;
        held = {out_valid_m, got[EW-2:0]};
      end
    end
  endtask

  // driver tasks: inputs change 1 time unit after the rising edge
  task automatic send_pix(input logic [7:0] p, input logic s, input bit gaps);
    int t;
    bit done;
    if (gaps && $urandom_range(0, 2) == 0) begin
      in_valid = 1'b0;
      @(posedge clk); #1;
    end
    in_pix = p; in_sof = s; in_valid = 1'b1;
    t = 0; done = 0;
    while (!done) begin
      @(negedge clk);
      if (in_ready_m) done = 1;
      @(posedge clk); #1;
      t++;
      if (!done && t > 200) begin
        tests_run++; tests_failed++;
        $display("FAIL send_pix_timeout: in_ready low for %0d cycles, required 1", t);
        done = 1;
      end
    end
    in_valid = 1'b0;
    in_sof = 1'b0;
  endtask

  task automatic drive_frame(input bit gaps);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        exp_q.push_back(exp_word(r, c));
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        send_pix(img[r][c], (r == 0 && c == 0), gaps);
  endtask

  task automatic wait_drain(input int n0, input int n_exp);
    int t = 0;
    while (exp_q.size() != 0 && t < 3000) begin
      @(posedge clk); #1;
      t++;
    end
    repeat (20) @(posedge clk);
    #1;
    tests_run++;
    if (exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL drain: %0d outputs missing, required 0", exp_q.size());
    end
    tests_run++;
    if (n_out - n0 != n_exp) begin
      tests_failed++;
      $display("FAIL out_count: got %0d required %0d", n_out - n0, n_exp);
    end
    tests_run++;
    if (dbg_state_m !== ST_IDLE) begin
      tests_failed++;
      $display("FAIL idle_after_frame: state %0d required %0d", dbg_state_m, ST_IDLE);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    tests_run++;
    if ({out_valid_m, out_pix_m, out_sof_m, out_eol_m, in_ready_m, in_ready_t} !== 13'h0) begin
      tests_failed++;
      $display("FAIL reset_outputs: valid=%b pix=%h sof=%b eol=%b rdy=%b/%b required all 0",
               out_valid_m, out_pix_m, out_sof_m, out_eol_m, in_ready_m, in_ready_t);
    end
    tests_run++;
    if (dbg_state_m !== ST_IDLE) begin
      tests_failed++;
      $display("FAIL reset_state: got %0d required %0d", dbg_state_m, ST_IDLE);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    tests_run++;
    if (in_ready_m !== 1'b1) begin
      tests_failed++;
      $display("FAIL idle_ready: got %b required 1", in_ready_m);
    end
    // non-sof pixels in IDLE are dropped
    for (int i = 0; i < 3; i++) send_pix(8'h11, 1'b0, 0);
    repeat (3) @(posedge clk);
    #1;
    tests_run++;
    if (dbg_state_m !== ST_IDLE || out_valid_m !== 1'b0) begin
      tests_failed++;
      $display("FAIL idle_drop: state %0d valid %b required %0d 0", dbg_state_m, out_valid_m, ST_IDLE);
    end
  endtask

  task automatic test_flat();
    int n0 = n_out;
    set_img(0); threshold = 8'h20;
    drive_frame(0);
    wait_drain(n0, W*H);
  endtask

  task automatic test_step();
    int n0 = n_out;
    set_img(1); threshold = 8'h80;
    drive_frame(0);
    wait_drain(n0, W*H);
  endtask

  task automatic test_ramp();
    int n0;
    set_img(2);
    n0 = n_out; threshold = 8'h50;
    drive_frame(0);
    wait_drain(n0, W*H);
    n0 = n_out; threshold = 8'h51;
    drive_frame(0);
    wait_drain(n0, W*H);
  endtask

  task automatic test_back_to_back_stall();
    int n0 = n_out;
    set_img(1); threshold = 8'h80;
    rnd_ready = 1'b1;
    drive_frame(1);
    wait_drain(n0, W*H);
    rnd_ready = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_sof_restart();
    int n0 = n_out;
    set_img(0); threshold = 8'h20;
    // inputs 9..19 of the abandoned frame produce centres 0..10 before the restart
    for (int k = 0; k <= 10; k++) exp_q.push_back(exp_word(k / W, k % W));
    for (int i = 0; i < 20; i++) send_pix(8'h40, (i == 0), 0);
    drive_frame(0);
    wait_drain(n0, 11 + W*H);
  endtask

  task automatic test_mid_reset();
    int n0;
    set_img(1); threshold = 8'h80;
    mon_en = 1'b0;
    for (int i = 0; i < 30; i++) send_pix(img[i / W][i % W], (i == 0), 0);
    tests_run++;
    if (dbg_state_m !== ST_RUN) begin
      tests_failed++;
      $display("FAIL pre_reset_state: got %0d required %0d", dbg_state_m, ST_RUN);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    tests_run++;
    if (out_valid_m !== 1'b0 || in_ready_m !== 1'b0 || dbg_state_m !== ST_IDLE) begin
      tests_failed++;
      $display("FAIL mid_reset: valid=%b ready=%b state=%0d required 0 0 %0d",
               out_valid_m, in_ready_m, dbg_state_m, ST_IDLE);
    end
    exp_q.delete();
    mon_en = 1'b1;
    n0 = n_out;
    drive_frame(0);
    wait_drain(n0, W*H);
  endtask

  initial begin
    fork
      monitor();
    join_none
    test_reset();
    test_flat();
    test_step();
    test_ramp();
    test_back_to_back_stall();
    test_sof_restart();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
